// File: rtl/trigger_pulse_gen_pkg.sv
// trigger_pulse_gen_pkg: shared state encoding, default widths and saturation limit.
package trigger_pulse_gen_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;
  localparam int DEF_WIDTH_BITS = 16;
  localparam int DEF_COUNT_BITS = 8;
  localparam logic [7:0] MISSED_MAX = 8'd255;
endpackage

// File: rtl/trigger_pulse_gen_timer.sv
// trigger_pulse_gen_timer: loadable down-counter; expired is high while the count sits at zero.
// Ports: clk, rst_n (async active-low), load/load_val (reload), expired.
module trigger_pulse_gen_timer
  import trigger_pulse_gen_pkg::*;
#(
  parameter int WIDTH_BITS = DEF_WIDTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH_BITS-1:0] load_val,
  output logic                  expired
);
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  // Stops at zero so a maximum load never wraps.
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - WIDTH_BITS'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = (cnt_q == '0);
endmodule

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: burst pulse generator (IDLE/HIGH/GAP) with shadowed config and missed-trigger count.
// Ports: clk, rst (async active-low), trigger_in, enable, pulse_width/pulse_gap/pulse_count + cfg_update,
//        pulse_out, busy, done (end-of-burst strobe), missed_count (saturating at 255).
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int WIDTH_BITS = DEF_WIDTH_BITS,
  parameter int COUNT_BITS = DEF_COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger_in,
  input  logic                  enable,
  input  logic [WIDTH_BITS-1:0] pulse_width,
  input  logic [WIDTH_BITS-1:0] pulse_gap,
  input  logic [COUNT_BITS-1:0] pulse_count,
  input  logic                  cfg_update,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            missed_count
);
  // Settings are stored raw; timers load (value-1) with 0 treated as 1.
  function automatic logic [WIDTH_BITS-1:0] dec_w(input logic [WIDTH_BITS-1:0] v);
    return (v == '0) ? '0 : v - WIDTH_BITS'(1);
  endfunction
  function automatic logic [COUNT_BITS-1:0] dec_c(input logic [COUNT_BITS-1:0] v);
    return (v == '0) ? '0 : v - COUNT_BITS'(1);
  endfunction
  // Reset asserts asynchronously but releases two edges later, clean to the clock.
  logic [1:0] sync_q, sync_d;
  logic       rst_n;
  always_comb sync_d = {sync_q[0], 1'b1};
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign rst_n = sync_q[1];
  state_e                state_q, state_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic [WIDTH_BITS-1:0] sh_w_q, sh_w_d, sh_g_q, sh_g_d, pend_w_q, pend_w_d, pend_g_q, pend_g_d;
  logic [COUNT_BITS-1:0] sh_c_q, sh_c_d, pend_c_q, pend_c_d;
  logic                  pend_q, pend_d, pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]            missed_q, missed_d;
  logic                  tmr_load, tmr_exp, idle, enter_idle, apply;
  logic [WIDTH_BITS-1:0] tmr_val, acc_w;
  logic [COUNT_BITS-1:0] acc_c;
  trigger_pulse_gen_timer #(.WIDTH_BITS(WIDTH_BITS)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );
  // A cfg_update coinciding with an accepted trigger takes effect for that burst.
  assign acc_w = cfg_update ? pulse_width : sh_w_q;
  assign acc_c = cfg_update ? pulse_count : sh_c_q;
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tmr_load = 1'b0;
    tmr_val  = dec_w(sh_w_q);
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (trigger_in && enable) begin
        state_d  = HIGH;
        tmr_load = 1'b1;
        tmr_val  = dec_w(acc_w);
        rem_d    = dec_c(acc_c);
      end
      HIGH: if (tmr_exp) begin
        state_d  = (rem_q == '0) ? IDLE : GAP;
        done_d   = (rem_q == '0);
        tmr_load = (rem_q != '0);
        tmr_val  = dec_w(sh_g_q);
        rem_d    = dec_c(rem_q);
      end
      GAP: if (tmr_exp) begin
        state_d  = HIGH;
        tmr_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    pulse_d  = (state_d == HIGH);
    busy_d   = (state_d != IDLE);
    missed_d = (trigger_in && state_q != IDLE && missed_q != MISSED_MAX) ? missed_q + 8'd1 : missed_q;
  end
  // Updates while busy are parked and applied on the edge that returns to IDLE.
  always_comb begin
    idle       = (state_q == IDLE);
    enter_idle = !idle && (state_d == IDLE);
    pend_w_d   = cfg_update ? pulse_width : pend_w_q;
    pend_g_d   = cfg_update ? pulse_gap : pend_g_q;
    pend_c_d   = cfg_update ? pulse_count : pend_c_q;
    pend_d     = (cfg_update || pend_q) && !idle && !enter_idle;
    apply      = (idle && cfg_update) || (enter_idle && (cfg_update || pend_q));
    sh_w_d     = apply ? pend_w_d : sh_w_q;
    sh_g_d     = apply ? pend_g_d : sh_g_q;
    sh_c_d     = apply ? pend_c_d : sh_c_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      sh_w_q   <= WIDTH_BITS'(1);
      sh_g_q   <= WIDTH_BITS'(1);
      sh_c_q   <= COUNT_BITS'(1);
      pend_w_q <= '0;
      pend_g_q <= '0;
      pend_c_q <= '0;
      pend_q   <= 1'b0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sh_w_q   <= sh_w_d;
      sh_g_q   <= sh_g_d;
      sh_c_q   <= sh_c_d;
      pend_w_q <= pend_w_d;
      pend_g_q <= pend_g_d;
      pend_c_q <= pend_c_d;
      pend_q   <= pend_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  assign pulse_out    = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign missed_count = missed_q;
endmodule

// File: doc/trigger_pulse_gen.md
TRIGGER_PULSE_GEN -- requirements
Module: TRIGGER_PULSE_GEN

Interface
REQ-001 Parameter WIDTH_BITS, default 16, is the bit width of the pulse width and gap counters.
REQ-002 Parameter COUNT_BITS, default 8, is the bit width of the burst pulse counter.
REQ-003 clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 trigger_in  input  1  single-cycle trigger pulse from the trigger delay stage.
REQ-006 enable  input  1  when 0, the block ignores triggers; a burst already running still completes.
REQ-007 pulse_width  input  WIDTH_BITS  high time of each pulse, in cycles.
REQ-008 pulse_gap  input  WIDTH_BITS  low time between pulses, in cycles.
REQ-009 pulse_count  input  COUNT_BITS  number of pulses per burst.
REQ-010 cfg_update  input  1  single-cycle strobe that loads the three config inputs.
REQ-011 pulse_out  output  1  registered glitch/trigger pulse output.
REQ-012 busy  output  1  high while a burst is in progress.
REQ-013 done  output  1  single-cycle strobe marking the end of a burst.
REQ-014 missed_count  output  8  count of triggers dropped while busy; saturates at 255.

Function
REQ-015 On cfg_update, config is loaded into shadow registers, immediately if IDLE, otherwise held pending and applied on the cycle of entering IDLE.
REQ-016 A burst always uses the shadow values latched at trigger acceptance; a mid-burst cfg_update never alters the running burst.
REQ-017 Width, gap or count equal to 0 is treated as 1.
REQ-018 The state machine has three states: IDLE, HIGH, GAP.
REQ-019 IDLE to HIGH occurs when trigger_in and enable are both 1.
REQ-020 HIGH to GAP occurs after width cycles in HIGH, if pulses remain.
REQ-021 HIGH to IDLE occurs after width cycles in HIGH, if this was the last pulse.
REQ-022 GAP to HIGH occurs after gap cycles in GAP.
REQ-023 Latency: trigger_in accepted at cycle N gives pulse_out=1 at cycle N+1.
REQ-024 pulse_out is exactly 1 in HIGH; no combinational path exists from trigger_in to pulse_out.
REQ-025 busy=1 in HIGH and GAP.
REQ-026 done=1 for exactly one cycle, on the first cycle in IDLE after the last HIGH.
REQ-027 A trigger arriving on the done cycle is accepted, starting a new burst with no gap.
REQ-028 trigger_in while busy is ignored and increments missed_count, saturating at 255.
REQ-029 trigger_in while enable=0 in IDLE is ignored and not counted.
REQ-030 Counters are WIDTH_BITS/COUNT_BITS wide; a maximum setting (65535) gives exactly 65535 cycles, with no wrap-around.
REQ-031 A cfg_update in the same cycle as an accepted trigger loads the new config first, and that burst uses the new values.

Reset
REQ-032 When rst=0, the block asynchronously enters IDLE with pulse_out=0, busy=0, done=0 and missed_count=0.
REQ-033 When rst=0, the shadow config resets to width=1, gap=1, count=1, and the pending flag clears.
REQ-034 Reset asserted mid-burst drops pulse_out within the same cycle; no done strobe is issued.
REQ-035 Reset release is synchronised internally, so the first active edge is clean.

Structure
REQ-036 The shared package holds the state enum (IDLE, HIGH, GAP), default WIDTH_BITS/COUNT_BITS, and MISSED_MAX=255.
REQ-037 Sub-module PULSE_TIMER is a loadable down-counter with an expire flag, instantiated for width/gap timing.
REQ-038 The block sits downstream of the trigger delay top; its trigger_in connects directly to that stage's trigger_out.

Verification
REQ-039 cfg width=4, gap=2, count=3; trigger at cycle 10 -> pulse_out high 11-14, 17-20, 23-26; done at 27; busy 11-26.
REQ-040 width=0, count=0, trigger -> single 1-cycle pulse, then done two cycles after the trigger.
REQ-041 width=10, count=1, trigger, then 300 more triggers during bursts -> missed_count saturates at 255.
REQ-042 cfg_update (width=8) mid-burst of width=3 -> current burst uses 3; the next trigger gives 8-cycle pulses.
REQ-043 rst asserted during HIGH -> pulse_out, busy=0 immediately; no done; the next trigger after release works normally.
REQ-044 enable=0 with trigger -> no pulse and missed_count unchanged; trigger on the done cycle -> back-to-back burst.
